// File: rtl/saph_fpu_arbiter.sv
// Round-robin share of one in-order FPU among GPUS requesters; issue and result routing are zero-latency combinational.
// Backpressure: req_ready drops when fpu_d_ready=0 or DEPTH tags are outstanding without a same-cycle result.
module saph_fpu_arbiter #(
    parameter int GPUS  = 2,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [GPUS-1:0]    req_valid,
    output logic [GPUS-1:0]    req_ready,
    input  logic [GPUS*32-1:0] req_lhs,
    input  logic [GPUS*32-1:0] req_rhs,
    input  logic [GPUS*2-1:0]  req_mode,
    output logic [GPUS-1:0]    res_valid,
    output logic [31:0]        res_data,
    output logic               fpu_d_trig,
    input  logic               fpu_d_ready,
    output logic [31:0]        fpu_d_lhs,
    output logic [31:0]        fpu_d_rhs,
    output logic [1:0]         fpu_d_mode,
    input  logic               fpu_q_trig,
    input  logic [31:0]        fpu_q_res,
    output logic               busy,
    output logic               err_orphan
);
    localparam int PW = (GPUS > 1) ? $clog2(GPUS) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          busy_q, busy_d;
    logic          err_orphan_q, err_orphan_d;
    logic [PW-1:0] tag_mem_q [DEPTH];

    logic [PW-1:0] grant_idx;
    logic [PW-1:0] cand;
    logic [PW-1:0] head_tag;
    logic          grant_any;
    logic          can_issue;
    logic          push;
    logic          pop;

    // Scan from the farthest offset to the nearest so the nearest valid requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = GPUS - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr_q) + k) % GPUS);
            if (req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        can_issue = !rst && fpu_d_ready && ((count_q < CW'(DEPTH)) || fpu_q_trig);
        push      = can_issue && grant_any;
        pop       = !rst && fpu_q_trig && (count_q != '0);
        head_tag  = tag_mem_q[rd_ptr_q];

        req_ready  = '0;
        res_valid  = '0;
        fpu_d_lhs  = '0;
        fpu_d_rhs  = '0;
        fpu_d_mode = '0;
        for (int i = 0; i < GPUS; i++) begin
            if (push && grant_idx == PW'(i)) begin
                req_ready[i] = 1'b1;
                fpu_d_lhs    = req_lhs[i*32 +: 32];
                fpu_d_rhs    = req_rhs[i*32 +: 32];
                fpu_d_mode   = req_mode[i*2 +: 2];
            end
            if (pop && head_tag == PW'(i)) begin
                res_valid[i] = 1'b1;
            end
        end
        fpu_d_trig = push;
        res_data   = fpu_q_res;

        ptr_d    = ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            ptr_d    = (grant_idx == PW'(GPUS - 1)) ? '0 : grant_idx + PW'(1);
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Simultaneous push and pop leave the occupancy unchanged, including when full.
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        busy_d       = (count_d != '0);
        err_orphan_d = err_orphan_q || (!rst && fpu_q_trig && count_q == '0);

        busy       = busy_q && !rst;
        err_orphan = err_orphan_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            busy_q       <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    // Tag storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= grant_idx;
        end
    end
endmodule

// File: tb/tb_saph_fpu_arbiter.sv
// Directed scenarios then random traffic, each cycle checked against a queue-based reference model.
module tb_saph_fpu_arbiter;
    localparam int GPUS  = 2;
    localparam int DEPTH = 4;

    logic               clk;
    logic               rst;
    logic [GPUS-1:0]    req_valid;
    logic [GPUS-1:0]    req_ready;
    logic [GPUS*32-1:0] req_lhs;
    logic [GPUS*32-1:0] req_rhs;
    logic [GPUS*2-1:0]  req_mode;
    logic [GPUS-1:0]    res_valid;
    logic [31:0]        res_data;
    logic               fpu_d_trig;
    logic               fpu_d_ready;
    logic [31:0]        fpu_d_lhs;
    logic [31:0]        fpu_d_rhs;
    logic [1:0]         fpu_d_mode;
    logic               fpu_q_trig;
    logic [31:0]        fpu_q_res;
    logic               busy;
    logic               err_orphan;

    int n_cmp = 0;
    int n_err = 0;

    int m_ptr = 0;
    int m_q[$];
    bit m_orphan = 0;

    saph_fpu_arbiter #(.GPUS(GPUS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_lhs(req_lhs), .req_rhs(req_rhs), .req_mode(req_mode),
        .res_valid(res_valid), .res_data(res_data),
        .fpu_d_trig(fpu_d_trig), .fpu_d_ready(fpu_d_ready),
        .fpu_d_lhs(fpu_d_lhs), .fpu_d_rhs(fpu_d_rhs), .fpu_d_mode(fpu_d_mode),
        .fpu_q_trig(fpu_q_trig), .fpu_q_res(fpu_q_res),
        .busy(busy), .err_orphan(err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [GPUS-1:0] v, input logic dr,
                         input logic qt, input logic [31:0] qres);
        rst         = r;
        req_valid   = v;
        fpu_d_ready = dr;
        fpu_q_trig  = qt;
        fpu_q_res   = qres;
        req_lhs     = {$urandom, $urandom};
        req_rhs     = {$urandom, $urandom};
        req_mode    = 4'($urandom);
    endtask

    // Compare every output against the model, then advance the model as of the coming edge.
    task automatic step();
        int  g;
        int  c;
        bit  any;
        bit  issue;
        bit  pop;
        logic [GPUS-1:0] e_rdy;
        logic [GPUS-1:0] e_rv;
        logic [31:0] e_lhs;
        logic [31:0] e_rhs;
        logic [1:0]  e_mode;
        g = 0; any = 0; issue = 0; pop = 0;
        e_rdy = '0; e_rv = '0; e_lhs = '0; e_rhs = '0; e_mode = '0;
        if (!rst) begin
            for (int k = 0; k < GPUS; k++) begin
                c = (m_ptr + k) % GPUS;
                if (!any && ((req_valid >> c) & GPUS'(1)) != '0) begin
                    any = 1;
                    g = c;
                end
            end
            issue = any && fpu_d_ready && (m_q.size() < DEPTH || fpu_q_trig);
            pop   = fpu_q_trig && m_q.size() > 0;
        end
        if (issue) begin
            e_rdy  = GPUS'(1) << g;
            e_lhs  = 32'(req_lhs >> (32 * g));
            e_rhs  = 32'(req_rhs >> (32 * g));
            e_mode = 2'(req_mode >> (2 * g));
        end
        if (pop) e_rv = GPUS'(1) << m_q[0];
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        chk("fpu_d_trig", 32'(fpu_d_trig), 32'(issue));
        chk("fpu_d_lhs", fpu_d_lhs, e_lhs);
        chk("fpu_d_rhs", fpu_d_rhs, e_rhs);
        chk("fpu_d_mode", 32'(fpu_d_mode), 32'(e_mode));
        chk("res_valid", 32'(res_valid), 32'(e_rv));
        if (pop) chk("res_data", res_data, fpu_q_res);
        chk("busy", 32'(busy), 32'(!rst && m_q.size() != 0));
        chk("err_orphan", 32'(err_orphan), 32'(m_orphan));
        if (rst) begin
            m_ptr = 0;
            m_q.delete();
            m_orphan = 0;
        end else begin
            if (fpu_q_trig && m_q.size() == 0) m_orphan = 1;
            if (pop) void'(m_q.pop_front());
            if (issue) begin
                m_q.push_back(g);
                m_ptr = (g + 1) % GPUS;
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input logic r, input logic [GPUS-1:0] v, input logic dr,
                       input logic qt, input logic [31:0] qres);
        drive(r, v, dr, qt, qres);
        #1;
        step();
    endtask

    initial begin
        drive(1'b1, '0, 1'b0, 1'b0, '0);
        @(negedge clk);

        // Reset ignores requests and results.
        run(1'b1, 2'b11, 1'b1, 1'b1, 32'h1);
        run(1'b1, 2'b11, 1'b1, 1'b1, 32'h2);
        drive(1'b0, 2'b00, 1'b1, 1'b0, '0);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_orphan", 32'(err_orphan), 32'd0);
        step();

        // Single requester with three-cycle FPU latency.
        drive(1'b0, 2'b10, 1'b1, 1'b0, '0);
        req_lhs[63:32] = 32'h3F800000;
        #1;
        chk("single_rdy", 32'(req_ready), 32'h2);
        chk("single_lhs", fpu_d_lhs, 32'h3F800000);
        step();
        run(1'b0, 2'b00, 1'b1, 1'b0, '0);
        run(1'b0, 2'b00, 1'b1, 1'b0, '0);
        drive(1'b0, 2'b00, 1'b1, 1'b1, 32'h40400000);
        #1;
        chk("single_rv", 32'(res_valid), 32'h2);
        chk("single_res", res_data, 32'h40400000);
        step();

        // Contention alternates grants; results come back in the same order.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b11, 1'b1, 1'b0, '0);
            #1;
            chk("cont_rdy", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b00, 1'b1, 1'b1, 32'(100 + i));
            #1;
            chk("cont_rv", 32'(res_valid), (i % 2 == 0) ? 32'h1 : 32'h2);
            step();
        end

        // Full: DEPTH issues, stall, then pop and push in the same cycle.
        for (int i = 0; i < DEPTH; i++) run(1'b0, 2'b11, 1'b1, 1'b0, '0);
        drive(1'b0, 2'b11, 1'b1, 1'b0, '0);
        #1;
        chk("full_rdy", 32'(req_ready), 32'h0);
        chk("full_trig", 32'(fpu_d_trig), 32'h0);
        step();
        drive(1'b0, 2'b11, 1'b1, 1'b1, 32'hABCD);
        #1;
        chk("full_swap_rdy", 32'(req_ready), 32'h1);
        chk("full_swap_rv", 32'(res_valid), 32'h1);
        step();
        drive(1'b0, 2'b11, 1'b1, 1'b0, '0);
        #1;
        chk("full_still_rdy", 32'(req_ready), 32'h0);
        chk("full_still_busy", 32'(busy), 32'h1);
        step();
        for (int i = 0; i < DEPTH; i++) run(1'b0, 2'b00, 1'b1, 1'b1, $urandom);

        // Backpressure holds the pointer.
        drive(1'b0, 2'b11, 1'b0, 1'b0, '0);
        #1;
        chk("bp_rdy", 32'(req_ready), 32'h0);
        step();
        drive(1'b0, 2'b11, 1'b1, 1'b0, '0);
        #1;
        chk("bp_release_rdy", 32'(req_ready), 32'h2);
        step();
        run(1'b0, 2'b00, 1'b1, 1'b1, 32'h55);

        // Orphan result is sticky until reset.
        drive(1'b0, 2'b00, 1'b1, 1'b1, 32'h77);
        #1;
        chk("orphan_rv", 32'(res_valid), 32'h0);
        step();
        for (int i = 0; i < 10; i++) run(1'b0, 2'b00, 1'b1, 1'b0, '0);
        drive(1'b0, 2'b00, 1'b1, 1'b0, '0);
        #1;
        chk("orphan_sticky", 32'(err_orphan), 32'h1);
        step();
        run(1'b1, 2'b00, 1'b1, 1'b0, '0);
        drive(1'b0, 2'b00, 1'b1, 1'b0, '0);
        #1;
        chk("orphan_cleared", 32'(err_orphan), 32'h0);
        step();

        // Reset mid-flight discards outstanding tags.
        for (int i = 0; i < 3; i++) run(1'b0, 2'b01, 1'b1, 1'b0, '0);
        run(1'b1, 2'b00, 1'b1, 1'b0, '0);
        drive(1'b0, 2'b00, 1'b1, 1'b0, '0);
        #1;
        chk("midrst_busy", 32'(busy), 32'h0);
        step();
        drive(1'b0, 2'b00, 1'b1, 1'b1, 32'h99);
        #1;
        chk("midrst_rv", 32'(res_valid), 32'h0);
        step();
        drive(1'b0, 2'b00, 1'b1, 1'b0, '0);
        #1;
        chk("midrst_orphan", 32'(err_orphan), 32'h1);
        step();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            run($urandom_range(0, 99) == 0, 2'($urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 9) < 4, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/saph_fpu_arbiter.md
SAPH_FPU_ARBITER -- requirements
Module: saph_fpu_arbiter

Interface
REQ-001 SHALL have parameter GPUS, default 2, number of requesting GPU ports (1..8).
REQ-002 SHALL have parameter DEPTH, default 4, maximum outstanding FPU operations tracked (power of two, 2..16).
REQ-003 SHALL have ports, one per line:
- clk  in  1  core clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  GPUS  per-GPU operation request.
- req_ready  out  GPUS  per-GPU grant; the operation is accepted when valid and ready are both high.
- req_lhs  in  GPUS*32  per-GPU left operand, GPU i at bits [32i+31:32i].
- req_rhs  in  GPUS*32  per-GPU right operand, same packing.
- req_mode  in  GPUS*2  per-GPU rounding mode.
- res_valid  out  GPUS  one-hot result strobe to the owning GPU.
- res_data  out  32  result data, broadcast to all GPUs.
- fpu_d_trig  out  1  issue strobe to the FPU.
- fpu_d_ready  in  1  FPU can accept an operation this cycle.
- fpu_d_lhs, fpu_d_rhs  out  32 each  operands of the granted GPU.
- fpu_d_mode  out  2  mode of the granted GPU.
- fpu_q_trig  in  1  FPU result strobe; results return in issue order.
- fpu_q_res  in  32  FPU result.
- busy  out  1  outstanding count is non-zero.
- err_orphan  out  1  sticky flag: a result arrived with no outstanding tag.

Function
REQ-004 SHALL hold a round-robin pointer ptr in the range 0..GPUS-1.
REQ-005 Grant index g SHALL be the first i in the order ptr, ptr+1, ..., wrapping modulo GPUS, for which req_valid[i]=1.
REQ-006 Issue (can_issue) SHALL be permitted when fpu_d_ready=1 and either count<DEPTH or fpu_q_trig=1 in the same cycle.
REQ-007 When can_issue=1 and any req_valid=1: req_ready SHALL be one-hot at g, and fpu_d_trig=1. Otherwise req_ready=0 and fpu_d_trig=0.
REQ-008 req_ready SHALL NOT depend combinationally on any req_valid other than those that determine g.
REQ-009 fpu_d_lhs, fpu_d_rhs and fpu_d_mode SHALL equal GPU g's fields when fpu_d_trig=1, and 0 otherwise.
REQ-010 On issue, ptr SHALL become (g+1) mod GPUS on the next edge; otherwise ptr SHALL hold.
REQ-011 On issue, tag g SHALL be pushed into an in-order tag FIFO of DEPTH entries (wrapping read/write pointers plus a count).
REQ-012 On fpu_q_trig=1 with count>0:
- the head tag SHALL be popped;
- res_valid SHALL be one-hot at the head tag in the same cycle (combinational, zero added latency);
- res_data SHALL equal fpu_q_res.
REQ-013 res_valid SHALL be 0 whenever fpu_q_trig=0. res_data SHALL be don't-care when res_valid=0.
REQ-014 A push and a pop in the same cycle SHALL leave count unchanged. This is legal when count=DEPTH (full) and when count=0 if the push and pop are separate operations; a pop never returns the tag being pushed that cycle.
REQ-015 fpu_q_trig=1 with count=0 SHALL:
- set err_orphan, which stays set until reset;
- keep res_valid=0;
- leave count at 0 (no underflow).
REQ-016 Fairness: a GPU holding req_valid=1 SHALL be granted within GPUS issue cycles.
REQ-017 busy SHALL be 1 iff count!=0, registered.
REQ-018 GPUS=1 SHALL degenerate to a pass-through with tag tracking. ptr stays 0.

Reset
REQ-019 While rst=1 at a clock edge, the following SHALL be cleared on that edge: ptr, count, FIFO pointers, err_orphan.
REQ-020 During reset: req_ready=0, fpu_d_trig=0, res_valid=0, busy=0. Requests and results arriving while rst=1 SHALL be ignored.
REQ-021 Reset asserted mid-operation SHALL discard all outstanding tags. Results arriving after reset releases then count as orphans.

Verification
REQ-022 Bench SHALL cover the following directed scenarios:
- Single requester: GPUS=2; GPU1 valid, lhs=0x3F800000; fpu_d_ready=1 -> req_ready=2'b10, fpu_d_lhs=0x3F800000; FPU latency 3 -> res_valid=2'b10 three cycles later; ptr=0.
- Contention: both GPUs valid for 4 cycles, fpu_d_ready=1 -> grants 01,10,01,10; results return in the same order with matching res_valid.
- Full: DEPTH=4, fpu_q_trig held 0 -> 4 issues, then req_ready=0 while count=4; fpu_q_trig=1 with a waiting request -> pop and push in the same cycle, count stays 4.
- Backpressure: fpu_d_ready=0 with both requests valid -> no grant, ptr holds; fpu_d_ready=1 -> grant at ptr.
- Orphan: fpu_q_trig=1 with count=0 -> err_orphan=1, res_valid=0; err_orphan still 1 ten cycles later; rst=1 -> err_orphan=0.
- Reset mid-flight: 3 outstanding, rst pulsed one cycle -> count=0, busy=0; next fpu_q_trig sets err_orphan.
